// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: 16-entry loadable code table, one coded bit per cycle.
// Optional error counter enabled by defining HUF_ERR_CNT_EN.
module huffman_decoder #(
   parameter int CODE_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tbl_wr,
   input  logic [3:0]        tbl_sym,
   input  logic [3:0]        tbl_len,
   input  logic [CODE_W-1:0] tbl_code,
   input  logic [CNT_W-1:0]  num_sym,
   input  logic              start,
   input  logic              bit_in,
   input  logic              bit_vld,
   output logic              bit_rdy,
   output logic [3:0]        sym_out,
   output logic              sym_vld,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [1:0]        state_dbg
);

   // Bit stream handshake: a bit transfers on every rising edge where bit_vld && bit_rdy.
   typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, DONE = 2'd2} state_t;

   state_t            state, state_nxt;
   logic [CODE_W-1:0] acc, acc_nxt, wr_code;
   logic [3:0]        len_cnt, len_nxt, hit_idx;
   logic [CNT_W-1:0]  dec_cnt, num_r;
   logic [3:0]        t_len  [16];
   logic [CODE_W-1:0] t_code [16];
   logic              accept, hit, last_sym, take_start, err_evt;

   assign accept   = (state == DECODE) && bit_vld;
   assign acc_nxt  = {acc[CODE_W-2:0], bit_in};
   assign len_nxt  = len_cnt + 4'd1;
   assign err_evt  = accept && !hit && (len_nxt == 4'(CODE_W));
   assign last_sym = hit && (CNT_W'(dec_cnt + 1'b1) == num_r);
   assign state_dbg = state;

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (t_len[i] == len_nxt && t_code[i] == acc_nxt) begin
            hit     = 1'b1;
            hit_idx = 4'(i);
         end
      end
   end

   // Bits above the codeword length are dropped so a full-width compare is exact.
   always_comb begin
      wr_code = '0;
      for (int b = 0; b < CODE_W; b++) begin
         wr_code[b] = tbl_code[b] & (b < int'(tbl_len));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      take_start = 1'b0;
      bit_rdy    = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start) begin
               take_start = 1'b1;
               state_nxt  = (num_sym == '0) ? DONE : DECODE;
            end
         end
         DECODE: begin
            bit_rdy = 1'b1;
            if (accept && last_sym) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         len_cnt <= '0;
         dec_cnt <= '0;
         num_r   <= '0;
         sym_out <= '0;
         sym_vld <= 1'b0;
         err     <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            t_len[i]  <= '0;
            t_code[i] <= '0;
         end
      end else begin
         sym_vld <= 1'b0;
         err     <= 1'b0;
         if (state == IDLE && tbl_wr) begin
            t_len[tbl_sym]  <= (tbl_len > 4'(CODE_W)) ? 4'd0 : tbl_len;
            t_code[tbl_sym] <= wr_code;
         end
         if (take_start) begin
            num_r   <= num_sym;
            dec_cnt <= '0;
            acc     <= '0;
            len_cnt <= '0;
         end
         if (accept) begin
            if (hit) begin
               sym_out <= hit_idx;
               sym_vld <= 1'b1;
               dec_cnt <= dec_cnt + 1'b1;
               acc     <= '0;
               len_cnt <= '0;
            end else if (err_evt) begin
               err     <= 1'b1;
               acc     <= '0;
               len_cnt <= '0;
            end else begin
               acc     <= acc_nxt;
               len_cnt <= len_nxt;
            end
         end
      end
   end

`ifdef HUF_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_r;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           err_cnt_r <= '0;
      else if (take_start)                  err_cnt_r <= '0;
      else if (err_evt && err_cnt_r != '1)  err_cnt_r <= err_cnt_r + 1'b1;
   end
   assign err_cnt = err_cnt_r;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: directed scenarios plus a random symbol
// stream encoded by a table-driven reference model.
module tb_huffman_decoder;

   logic       clk, rst_n, tbl_wr, start, bit_in, bit_vld;
   logic [3:0] tbl_sym, tbl_len;
   logic [7:0] tbl_code, num_sym;
   logic       bit_rdy, sym_vld, done, err;
   logic [3:0] sym_out;
   logic [7:0] err_cnt;
   logic [1:0] state_dbg;

   int n_cmp = 0;
   int n_fail = 0;
   int n_sym_seen = 0;
   int n_err_seen = 0;
   int stall_waits = 0;

   logic [3:0] exp_q[$];
   logic       bit_q[$];
   int         tb_len  [16];
   logic [7:0] tb_code [16];

`ifdef HUF_ERR_CNT_EN
   localparam logic [7:0] EC_AFTER_ERR = 8'd1;
`else
   localparam logic [7:0] EC_AFTER_ERR = 8'd0;
`endif

   huffman_decoder #(.CODE_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .tbl_wr(tbl_wr), .tbl_sym(tbl_sym), .tbl_len(tbl_len),
      .tbl_code(tbl_code), .num_sym(num_sym), .start(start), .bit_in(bit_in),
      .bit_vld(bit_vld), .bit_rdy(bit_rdy), .sym_out(sym_out), .sym_vld(sym_vld),
      .done(done), .err(err), .err_cnt(err_cnt), .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every symbol pulse must match the next expected symbol.
   always @(negedge clk) begin
      if (rst_n && sym_vld) begin
         n_sym_seen++;
         if (exp_q.size() == 0) check("unexpected_sym_vld", 32'(sym_out), 32'hDEAD);
         else                   check("sym_out", 32'(sym_out), 32'(exp_q.pop_front()));
      end
      if (rst_n && err) n_err_seen++;
   end

   task automatic reset_dut();
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) tb_len[i] = 0;
      @(posedge clk); #1;
   endtask

   task automatic load(input int sym, input int len, input logic [7:0] code);
      tbl_wr = 1'b1; tbl_sym = 4'(sym); tbl_len = 4'(len); tbl_code = code;
      @(posedge clk); #1;
      tbl_wr = 1'b0;
      tb_len[sym] = len; tb_code[sym] = code;
   endtask

   task automatic do_start(input int n);
      start = 1'b1; num_sym = 8'(n);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic encode(input int sym);
      logic [7:0] c;
      c = tb_code[sym];
      for (int b = tb_len[sym] - 1; b >= 0; b--) bit_q.push_back(c[b]);
   endtask

   task automatic send_bit(input logic b);
      int w;
      bit_in = b; bit_vld = 1'b1; w = 0;
      while (!bit_rdy && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      stall_waits += w;
      if (!bit_rdy) check("bit_rdy_timeout", 32'(bit_rdy), 32'd1);
      @(posedge clk); #1;
      bit_vld = 1'b0;
   endtask

   task automatic bit_chk(input logic b, input logic exp_vld, input logic exp_err);
      send_bit(b);
      check("sym_vld_timing", 32'(sym_vld), 32'(exp_vld));
      check("err_timing", 32'(err), 32'(exp_err));
   endtask

   task automatic stall_cycle();
      bit_vld = 1'b0;
      @(posedge clk); #1;
      check("sym_vld_stall", 32'(sym_vld), 32'd0);
   endtask

   initial begin
      int sym;
      rst_n = 1'b0; tbl_wr = 1'b0; tbl_sym = '0; tbl_len = '0; tbl_code = '0;
      num_sym = '0; start = 1'b0; bit_in = 1'b0; bit_vld = 1'b0;
      for (int i = 0; i < 16; i++) begin tb_len[i] = 0; tb_code[i] = '0; end
      repeat (2) @(posedge clk); #1;

      // Reset state
      check("rst_bit_rdy", 32'(bit_rdy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sym_vld", 32'(sym_vld), 32'd0);
      check("rst_sym_out", 32'(sym_out), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_state_idle", 32'(state_dbg), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic three-symbol decode: bits 0,1,0,1,1 -> 1,2,3
      load(1, 1, 8'b0); load(2, 2, 8'b10); load(3, 2, 8'b11);
      do_start(3);
      check("decode_bit_rdy", 32'(bit_rdy), 32'd1);
      exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
      bit_chk(1'b0, 1'b1, 1'b0);
      bit_chk(1'b1, 1'b0, 1'b0);
      bit_chk(1'b0, 1'b1, 1'b0);
      bit_chk(1'b1, 1'b0, 1'b0);
      bit_chk(1'b1, 1'b1, 1'b0);
      check("basic_done", 32'(done), 32'd1);
      check("basic_bit_rdy_low", 32'(bit_rdy), 32'd0);

      // Table write in DONE must be ignored; then the same stream at half rate
      tbl_wr = 1'b1; tbl_sym = 4'd1; tbl_len = 4'd0; tbl_code = 8'h00;
      @(posedge clk); #1;
      tbl_wr = 1'b0;
      do_start(3);
      exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
      bit_chk(1'b0, 1'b1, 1'b0); stall_cycle();
      bit_chk(1'b1, 1'b0, 1'b0); stall_cycle();
      bit_chk(1'b0, 1'b1, 1'b0); stall_cycle();
      bit_chk(1'b1, 1'b0, 1'b0); stall_cycle();
      bit_chk(1'b1, 1'b1, 1'b0);
      check("stall_done", 32'(done), 32'd1);

      // Undecodable codeword: eight 1s against a table of "00","01"
      reset_dut();
      load(0, 2, 8'b00); load(1, 2, 8'b01);
      do_start(1);
      for (int i = 0; i < 7; i++) bit_chk(1'b1, 1'b0, 1'b0);
      bit_chk(1'b1, 1'b0, 1'b1);
      check("err_cnt_after_err", 32'(err_cnt), 32'(EC_AFTER_ERR));
      exp_q.push_back(4'd1);
      bit_chk(1'b0, 1'b0, 1'b0);
      bit_chk(1'b1, 1'b1, 1'b0);
      check("err_recover_done", 32'(done), 32'd1);
      do_start(0);
      check("err_cnt_clear_on_start", 32'(err_cnt), 32'd0);
      check("zero_start_from_done", 32'(done), 32'd1);

      // Reset in the middle of a 2-bit code
      reset_dut();
      load(2, 2, 8'b10);
      do_start(1);
      bit_chk(1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      check("midrst_sym_vld", 32'(sym_vld), 32'd0);
      check("midrst_bit_rdy", 32'(bit_rdy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_state_idle", 32'(state_dbg), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      load(2, 2, 8'b10);
      do_start(1);
      exp_q.push_back(4'd2);
      bit_chk(1'b1, 1'b0, 1'b0);
      bit_chk(1'b0, 1'b1, 1'b0);
      check("midrst_reload_done", 32'(done), 32'd1);

      // Duplicate code: lowest index wins
      reset_dut();
      load(5, 2, 8'b10); load(9, 2, 8'b10);
      do_start(1);
      exp_q.push_back(4'd5);
      bit_chk(1'b1, 1'b0, 1'b0);
      bit_chk(1'b0, 1'b1, 1'b0);
      check("dup_sym_out", 32'(sym_out), 32'd5);

      // Num_sym == 0 from IDLE: Done on the next cycle, never ready for bits
      reset_dut();
      do_start(0);
      check("zero_done", 32'(done), 32'd1);
      for (int i = 0; i < 3; i++) begin
         check("zero_bit_rdy", 32'(bit_rdy), 32'd0);
         @(posedge clk); #1;
      end

      // Random stream of 255 symbols over a complete 10-entry prefix code
      reset_dut();
      load(0, 2, 8'b00);
      load(1, 3, 8'b010);  load(2, 3, 8'b011);  load(3, 3, 8'b100);  load(4, 3, 8'b101);
      load(5, 4, 8'b1100); load(6, 4, 8'b1101); load(7, 4, 8'b1110);
      load(8, 5, 8'b11110); load(9, 5, 8'b11111);
      n_sym_seen = 0;
      stall_waits = 0;
      for (int i = 0; i < 255; i++) begin
         sym = int'($urandom_range(9, 0));
         exp_q.push_back(4'(sym));
         encode(sym);
      end
      do_start(255);
      while (bit_q.size() > 0) send_bit(bit_q.pop_front());
      @(posedge clk); #1;
      check("rand_sym_count", 32'(n_sym_seen), 32'd255);
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
      check("rand_no_rdy_gaps", 32'(stall_waits), 32'd0);
      check("rand_done", 32'(done), 32'd1);
      check("total_err_pulses", 32'(n_err_seen), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
